// File: rtl/rf_pkg.sv
// Shared types and helpers for the multi-port register file.
// Holds the dump FSM encoding and the write-to-read forwarding test.
package rf_pkg;

  localparam int XLEN_DEF = 32;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } dump_st_e;

  function automatic logic rf_bypass(
    input logic        we,
    input logic [15:0] waddr,
    input logic [15:0] raddr
  );
    return we && (waddr == raddr);
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy bits for hazard detection.
// Reservation beats a same-cycle write so the newest producer is tracked.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int NREG     = 32,
  parameter int AW       = $clog2(NREG),
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic            rsv_valid,
  input  logic [AW-1:0]   rsv_addr,
  input  logic [NRD*AW-1:0] raddr,
  output logic [NRD-1:0]  rbusy
);

  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_n;

  always_comb begin
    busy_n = busy;
    for (int i = 0; i < NREG; i++) begin
      if (rsv_valid && rsv_addr == AW'(i))
        busy_n[i] = 1'b1;
      else if (we && waddr == AW'(i))
        busy_n[i] = 1'b0;
    end
    if (ZERO_REG != 0)
      busy_n[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      busy <= '0;
    else
      busy <= busy_n;
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rb
    logic [AW-1:0] ra;
    assign ra = raddr[k*AW +: AW];
    // only the clear is forwarded; a new reservation shows next cycle
    assign rbusy[k] = busy[ra] &
      ~rf_bypass(we, 16'(waddr), 16'(ra));
  end

endmodule

// File: rtl/rf_multiport.sv
// Register file with NRD bypassed read ports, one write port,
// a busy scoreboard and a valid/ready dump engine.
module rf_multiport
  import rf_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int NREG     = 32,
  parameter int AW       = $clog2(NREG),
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [XLEN-1:0]   wdata,
  input  logic [NRD*AW-1:0] raddr,
  output logic [NRD*XLEN-1:0] rdata,
  output logic [NRD-1:0]    rbusy,
  input  logic              rsv_valid,
  input  logic [AW-1:0]     rsv_addr,
  input  logic              dump_req,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [AW-1:0]     dump_addr,
  output logic [XLEN-1:0]   dump_data,
  output logic              dump_done
);

  logic [XLEN-1:0] mem [NREG];
  logic            wr_ok;

  assign wr_ok = we &&
    !(ZERO_REG != 0 && waddr == '0);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NREG; i++)
        mem[i] <= '0;
    end else if (wr_ok) begin
      mem[waddr] <= wdata;
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] rd;
    assign ra = raddr[k*AW +: AW];
    always_comb begin
      if (ZERO_REG != 0 && ra == '0)
        rd = '0;
      else if (rf_bypass(we, 16'(waddr), 16'(ra)))
        rd = wdata;
      else
        rd = mem[ra];
    end
    assign rdata[k*XLEN +: XLEN] = rd;
  end

  rf_scoreboard #(
    .NREG     (NREG),
    .AW       (AW),
    .NRD      (NRD),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk       (clk),
    .rstn      (rstn),
    .we        (we),
    .waddr     (waddr),
    .rsv_valid (rsv_valid),
    .rsv_addr  (rsv_addr),
    .raddr     (raddr),
    .rbusy     (rbusy)
  );

  dump_st_e        st, st_n;
  logic [AW-1:0]   addr_n;
  logic [XLEN-1:0] data_n;
  logic [AW-1:0]   da;
  logic [XLEN-1:0] da_eff;

  // single extra read port feeding the next dump beat
  assign da = (st == IDLE) ? '0 : dump_addr + 1'b1;

  always_comb begin
    if (ZERO_REG != 0 && da == '0)
      da_eff = '0;
    else if (rf_bypass(we, 16'(waddr), 16'(da)))
      da_eff = wdata;
    else
      da_eff = mem[da];
  end

  always_comb begin
    st_n   = st;
    addr_n = dump_addr;
    data_n = dump_data;
    unique case (st)
      IDLE: if (dump_req) begin
        st_n   = RUN;
        addr_n = '0;
        data_n = da_eff;
      end
      RUN: if (dump_ready) begin
        if (dump_addr == AW'(NREG - 1)) begin
          st_n = DONE;
        end else begin
          addr_n = da;
          data_n = da_eff;
        end
      end
      DONE: st_n = IDLE;
      default: st_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      st        <= IDLE;
      dump_addr <= '0;
      dump_data <= '0;
    end else begin
      st        <= st_n;
      dump_addr <= addr_n;
      dump_data <= data_n;
    end
  end

  assign dump_valid = (st == RUN);
  assign dump_done  = (st == DONE);

endmodule

// File: tb/tb_rf_multiport.sv
// Self-checking bench for rf_multiport: vector table, random
// traffic against an array model, and dump/abort sequences.
module tb_rf_multiport;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = 5;
  localparam int NRD  = 2;

  logic              clk = 1'b0;
  logic              rstn;
  logic              we;
  logic [AW-1:0]     waddr;
  logic [XLEN-1:0]   wdata;
  logic [NRD*AW-1:0] raddr;
  logic [NRD*XLEN-1:0] rdata;
  logic [NRD-1:0]    rbusy;
  logic              rsv_valid;
  logic [AW-1:0]     rsv_addr;
  logic              dump_req;
  logic              dump_valid;
  logic              dump_ready;
  logic [AW-1:0]     dump_addr;
  logic [XLEN-1:0]   dump_data;
  logic              dump_done;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  rf_multiport #(
    .XLEN(XLEN), .NREG(NREG), .NRD(NRD), .ZERO_REG(1)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .we         (we),
    .waddr      (waddr),
    .wdata      (wdata),
    .raddr      (raddr),
    .rdata      (rdata),
    .rbusy      (rbusy),
    .rsv_valid  (rsv_valid),
    .rsv_addr   (rsv_addr),
    .dump_req   (dump_req),
    .dump_valid (dump_valid),
    .dump_ready (dump_ready),
    .dump_addr  (dump_addr),
    .dump_data  (dump_data),
    .dump_done  (dump_done)
  );

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic        rsv;
    logic [4:0]  rsa;
    logic [31:0] e0;
    logic [31:0] e1;
    logic [1:0]  eb;
  } vec_t;

  vec_t tv [16];

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic idle_in();
    we = 0; waddr = 0; wdata = 0; raddr = 0;
    rsv_valid = 0; rsv_addr = 0;
    dump_req = 0; dump_ready = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_in();
    rstn = 0;
    repeat (2) @(negedge clk);
    rstn = 1;
  endtask

  task automatic wr(input logic [4:0] a,
                    input logic [31:0] d);
    @(negedge clk);
    idle_in();
    we = 1; waddr = a; wdata = d;
    @(negedge clk);
    idle_in();
  endtask

  task automatic fill_k11();
    for (int k = 1; k < NREG; k++)
      wr(5'(k), 32'(k * 32'h11));
  endtask

  logic [31:0] m [NREG];
  logic        b [NREG];

  initial begin
    tv[0]  = '{0, 0, 0,        0, 5, 0, 0, 0,        0, 2'b00};
    tv[1]  = '{1, 5, 32'h12345678, 5, 1, 0, 0,
               32'h12345678, 0, 2'b00};
    tv[2]  = '{0, 0, 0, 5, 0, 0, 0, 32'h12345678, 0, 2'b00};
    tv[3]  = '{1, 7, 32'hDEADBEEF, 7, 5, 0, 0,
               32'hDEADBEEF, 32'h12345678, 2'b00};
    tv[4]  = '{1, 0, 32'hFFFFFFFF, 0, 7, 0, 0,
               0, 32'hDEADBEEF, 2'b00};
    tv[5]  = '{0, 0, 0, 0, 7, 1, 0, 0, 32'hDEADBEEF, 2'b00};
    tv[6]  = '{0, 0, 0, 3, 0, 1, 3, 0, 0, 2'b00};
    tv[7]  = '{0, 0, 0, 3, 0, 0, 0, 0, 0, 2'b01};
    tv[8]  = '{1, 3, 32'h33, 3, 3, 0, 0,
               32'h33, 32'h33, 2'b00};
    tv[9]  = '{0, 0, 0, 3, 5, 0, 0, 32'h33,
               32'h12345678, 2'b00};
    tv[10] = '{1, 3, 32'h44, 3, 0, 1, 3, 32'h44, 0, 2'b00};
    tv[11] = '{0, 0, 0, 3, 0, 0, 0, 32'h44, 0, 2'b01};
    tv[12] = '{0, 0, 0, 3, 9, 1, 9, 32'h44, 0, 2'b01};
    tv[13] = '{0, 0, 0, 3, 9, 0, 0, 32'h44, 0, 2'b11};
    tv[14] = '{1, 9, 32'h9, 3, 9, 0, 0,
               32'h44, 32'h9, 2'b01};
    tv[15] = '{1, 3, 32'h55, 3, 9, 0, 0,
               32'h55, 32'h9, 2'b00};

    rstn = 0;
    idle_in();
    #1;
    chk("rst_rdata", rdata, 0);
    chk("rst_rbusy", rbusy, 0);
    chk("rst_dvalid", dump_valid, 0);
    chk("rst_ddone", dump_done, 0);
    do_reset();

    // directed vectors
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      idle_in();
      we = tv[i].we; waddr = tv[i].wa; wdata = tv[i].wd;
      raddr = {tv[i].ra1, tv[i].ra0};
      rsv_valid = tv[i].rsv; rsv_addr = tv[i].rsa;
      #2;
      chk($sformatf("vec%0d_rd0", i),
          rdata[31:0], tv[i].e0);
      chk($sformatf("vec%0d_rd1", i),
          rdata[63:32], tv[i].e1);
      chk($sformatf("vec%0d_busy", i), rbusy, tv[i].eb);
    end

    // random traffic vs array model
    do_reset();
    for (int i = 0; i < NREG; i++) begin
      m[i] = 0; b[i] = 0;
    end
    for (int c = 0; c < 400; c++) begin
      logic [4:0]  ra [2];
      logic [31:0] ed;
      logic        eb;
      @(negedge clk);
      idle_in();
      we = 1'($urandom_range(0, 1));
      waddr = 5'($urandom_range(0, 7));
      wdata = $urandom;
      rsv_valid = 1'($urandom_range(0, 1));
      rsv_addr = 5'($urandom_range(0, 7));
      ra[0] = 5'($urandom_range(0, 7));
      ra[1] = 5'($urandom_range(0, 7));
      raddr = {ra[1], ra[0]};
      #2;
      for (int k = 0; k < 2; k++) begin
        if (ra[k] == 0) ed = 0;
        else if (we && waddr == ra[k]) ed = wdata;
        else ed = m[ra[k]];
        eb = b[ra[k]] && !(we && waddr == ra[k]);
        chk($sformatf("rnd%0d_rd%0d", c, k),
            rdata[k*32 +: 32], ed);
        chk($sformatf("rnd%0d_busy%0d", c, k),
            rbusy[k], eb);
      end
      if (we && waddr != 0) m[waddr] = wdata;
      if (we) b[waddr] = 0;
      if (rsv_valid && rsv_addr != 0) b[rsv_addr] = 1;
    end

    // dump with ready toggling, a stalled-beat write,
    // and a mid-dump request that must be ignored
    do_reset();
    fill_k11();
    begin
      int idx = 0;
      int ndone = 0;
      int c = 0;
      for (c = 0; c < 200 && !(ndone > 0 && idx == NREG && c > 80); c++) begin
        @(negedge clk);
        idle_in();
        dump_req = (c == 0) || (c == 20);
        dump_ready = c[0];
        if (idx == 10 && !dump_ready && dump_valid) begin
          we = 1; waddr = 10; wdata = 32'hABC;
        end
        #2;
        if (c == 0) chk("dump_req_cycle_valid", dump_valid, 0);
        if (c == 1) chk("dump_first_valid", dump_valid, 1);
        if (dump_done) ndone++;
        if (dump_valid) begin
          if (idx >= NREG) chk("dump_extra_beat", idx, NREG - 1);
          else begin
            chk($sformatf("dump_addr%0d", idx), dump_addr, idx);
            chk($sformatf("dump_data%0d", idx), dump_data,
                idx * 32'h11);
          end
          if (dump_ready) idx++;
        end
      end
      chk("dump_beats", idx, NREG);
      chk("dump_done_count", ndone, 1);
      chk("dump_idle_after", dump_valid, 0);
    end

    // reset during beat 10 aborts the dump
    do_reset();
    fill_k11();
    begin
      int c = 0;
      @(negedge clk);
      dump_req = 1;
      @(negedge clk);
      dump_req = 0;
      dump_ready = 1;
      for (c = 0; c < 100; c++) begin
        #2;
        if (dump_valid && dump_addr == 10) break;
        @(negedge clk);
      end
      if (c == 100) chk("abort_reach_beat10", 0, 1);
      rstn = 0;
      #1;
      chk("abort_valid", dump_valid, 0);
      chk("abort_done", dump_done, 0);
      chk("abort_addr", dump_addr, 0);
      chk("abort_data", dump_data, 0);
      raddr = {5'd20, 5'd5};
      #1;
      chk("abort_r5", rdata[31:0], 0);
      chk("abort_r20", rdata[63:32], 0);
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        chk("abort_no_done", dump_done, 0);
      end
      rstn = 1;
      dump_ready = 0;
      @(negedge clk);
      dump_req = 1;
      @(negedge clk);
      dump_req = 0;
      #2;
      chk("redump_valid", dump_valid, 1);
      chk("redump_addr", dump_addr, 0);
      chk("redump_data", dump_data, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
